pixel_plotter: RTL and testbench

- Downstream stage for the generated shape-generator modules: consumes their (x, y) coordinate stream and rasterises it into an internal WIDTH x HEIGHT framebuffer.
- Each frame runs clear, then plot, then raster-order readout to the display/checker stage under a valid/ready handshake.
- Keeps plotted and clipped pixel counts for verification against the Python model.

---
 rtl/pixel_plotter.sv | 163 ++++++++++++++++
 tb/tb_pixel_plotter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plotter.sv
// Rasterises a stream of signed (x, y) coordinates into a WIDTH x HEIGHT framebuffer.
// Each frame clears the buffer, plots the coordinate stream, then reads it out in raster order.
module pixel_plotter #(
    parameter int                 WIDTH       = 8,
    parameter int                 HEIGHT      = 8,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input  logic                      _clock,
    input  logic                      _reset,
    input  logic                      _start,
    input  logic [COLOR_W-1:0]        color,
    input  logic signed [31:0]        _in0,
    input  logic signed [31:0]        _in1,
    input  logic                      _in_valid,
    input  logic                      _in_done,
    output logic                      _ready,
    output logic signed [31:0]        _out0,
    output logic signed [31:0]        _out1,
    output logic [COLOR_W-1:0]        _out_color,
    output logic                      _out_valid,
    input  logic                      _out_ready,
    output logic [31:0]               plotted_count,
    output logic [31:0]               clipped_count,
    output logic                      _done
);

    localparam int N = WIDTH * HEIGHT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [8:0] X_LAST = 9'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_PLOT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [COLOR_W-1:0] plot_color;
    logic               done_seen;
    logic               all_issued;
    logic [8:0]         rd_x;
    logic [8:0]         rd_y;
    logic [COLOR_W-1:0] mem [N];

    logic               accept;
    logic               in_bounds;
    logic               advance;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_addr;
    logic [COLOR_W-1:0] wr_data;

    assign _ready    = (state == S_PLOT);
    assign _done     = (state == S_FIN);
    assign accept    = (state == S_PLOT) && _in_valid;
    assign in_bounds = (_in0 >= 0) && (_in0 < WIDTH) && (_in1 >= 0) && (_in1 < HEIGHT);
    // The output register may load a new beat when it is empty or its beat is being taken.
    assign advance   = (state == S_DRAIN) && (!_out_valid || _out_ready);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = idx;
        wr_data = CLEAR_COLOR;
        if (!_reset) begin
            if (state == S_CLEAR) begin
                wr_en = 1'b1;
            end else if (accept && in_bounds) begin
                wr_en   = 1'b1;
                wr_addr = IDX_W'(_in1 * WIDTH + _in0);
                wr_data = plot_color;
            end
        end
    end

    // NOTE: the framebuffer has no reset; CLEAR rewrites every pixel before it is read.
    always_ff @(posedge _clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            plot_color    <= '0;
            done_seen     <= 1'b0;
            all_issued    <= 1'b0;
            rd_x          <= '0;
            rd_y          <= '0;
            _out0         <= '0;
            _out1         <= '0;
            _out_color    <= '0;
            _out_valid    <= 1'b0;
            plotted_count <= '0;
            clipped_count <= '0;
        end else begin
            if (_in_done) done_seen <= 1'b1;
            case (state)
                S_IDLE, S_FIN: begin
                    if (_start) begin
                        plot_color    <= color;
                        plotted_count <= '0;
                        clipped_count <= '0;
                        done_seen     <= 1'b0;
                        idx           <= '0;
                        state         <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_PLOT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_PLOT: begin
                    if (accept) begin
                        if (in_bounds) plotted_count <= plotted_count + 32'd1;
                        else           clipped_count <= clipped_count + 32'd1;
                    end
                    if (_in_done || done_seen) begin
                        idx        <= '0;
                        rd_x       <= '0;
                        rd_y       <= '0;
                        all_issued <= 1'b0;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (advance) begin
                        if (!all_issued) begin
                            _out_color <= mem[idx];
                            _out0      <= 32'(rd_x);
                            _out1      <= 32'(rd_y);
                            _out_valid <= 1'b1;
                            if (idx == LAST_IDX) begin
                                all_issued <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                                if (rd_x == X_LAST) begin
                                    rd_x <= '0;
                                    rd_y <= rd_y + 9'd1;
                                end else begin
                                    rd_x <= rd_x + 9'd1;
                                end
                            end
                        end else begin
                            // Last beat was taken this cycle.
                            _out_valid <= 1'b0;
                            state      <= S_FIN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_plotter.sv
// Randomised self-checking bench for pixel_plotter against a framebuffer-array reference model.
module tb_pixel_plotter;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 8;
    localparam int N  = W * H;
    localparam logic [CW-1:0] CLR = '0;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [CW-1:0]        color = '0;
    logic signed [31:0]   in0 = '0;
    logic signed [31:0]   in1 = '0;
    logic                 in_valid = 1'b0;
    logic                 in_done = 1'b0;
    logic                 ready;
    logic signed [31:0]   out0;
    logic signed [31:0]   out1;
    logic [CW-1:0]        out_color;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [31:0]          plotted;
    logic [31:0]          clipped;
    logic                 done;

    always #5 clk = ~clk;

    pixel_plotter #(.WIDTH(W), .HEIGHT(H), .COLOR_W(CW), .CLEAR_COLOR(CLR)) dut (
        ._clock(clk), ._reset(rst), ._start(start), .color(color),
        ._in0(in0), ._in1(in1), ._in_valid(in_valid), ._in_done(in_done),
        ._ready(ready), ._out0(out0), ._out1(out1), ._out_color(out_color),
        ._out_valid(out_valid), ._out_ready(out_ready),
        .plotted_count(plotted), .clipped_count(clipped), ._done(done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the picture a frame should produce and its counters.
    int            exp_fb [N];
    int            exp_plot;
    int            exp_clip;
    logic [CW-1:0] cur_col;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start(input logic [CW-1:0] c);
        cur_col  = c;
        exp_plot = 0;
        exp_clip = 0;
        for (int i = 0; i < N; i++) exp_fb[i] = int'(CLR);
    endtask

    task automatic model_plot(input int x, input int y);
        if (x >= 0 && x < W && y >= 0 && y < H) begin
            exp_fb[y * W + x] = int'(cur_col);
            exp_plot++;
        end else begin
            exp_clip++;
        end
    endtask

    // Start a frame and wait for PLOT, poking ignored coordinates (and optionally _in_done) meanwhile.
    task automatic start_frame(input logic [CW-1:0] c, input bit done_in_clear);
        int n;
        model_start(c);
        start = 1'b1;
        color = c;
        tick();
        start = 1'b0;
        color = CW'($urandom);
        check("done_low_after_start", done, 0);
        n = 0;
        while (!ready && n < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in0      = $urandom_range(0, W - 1);
            in1      = $urandom_range(0, H - 1);
            in_done  = done_in_clear && (n == 3);
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_done  = 1'b0;
        check("ready_latency", n, N);
    endtask

    task automatic send(input int x, input int y, input bit with_done);
        check("ready_in_plot", ready, 1);
        in0      = x;
        in1      = y;
        in_valid = 1'b1;
        in_done  = with_done;
        model_plot(x, y);
        tick();
        in_valid = 1'b0;
        in_done  = 1'b0;
        if (!with_done) repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic pulse_done();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
    endtask

    // Collect readout beats; mode 0 = ready high, 1 = toggling, 2 = random.
    task automatic drain(input int mode, input int limit);
        int   beats = 0;
        int   cyc = 0;
        bit   stalled = 0;
        bit   rdy;
        logic [95:0] held = '0;
        while (beats < limit && cyc < 1000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (stalled) check("stall_hold", {out_valid, out0, out1, out_color}, held);
            stalled = 0;
            if (out_valid) begin
                if (rdy) begin
                    check("beat_x", out0, beats % W);
                    check("beat_y", out1, beats / W);
                    check("beat_color", out_color, exp_fb[beats]);
                    beats++;
                end else begin
                    stalled = 1;
                    held    = {1'b1, out0, out1, out_color};
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("beat_count", beats, limit);
        if (mode == 0) check("drain_cycles", cyc, limit + 1);
        if (limit == N) begin
            check("fin_valid_low", out_valid, 0);
            check("fin_done", done, 1);
            check("plotted_count", plotted, exp_plot);
            check("clipped_count", clipped, exp_clip);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle behaviour.
        tick();
        tick();
        check("rst_ready", ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_outs", {out0, out1, out_color}, 0);
        check("rst_counts", {plotted, clipped}, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in0      = i;
            in1      = i;
            tick();
        end
        in_valid = 1'b0;
        check("idle_ready", ready, 0);
        check("idle_counts", {plotted, clipped}, 0);

        // Small rectangle with gaps between beats.
        start_frame(8'd5, 0);
        for (int y = 2; y <= 3; y++)
            for (int x = 1; x <= 3; x++) send(x, y, 0);
        pulse_done();
        drain(0, N);

        // Clipping edges, last coordinate arrives with _in_done.
        start_frame(CW'($urandom_range(1, 255)), 0);
        send(-1, 0, 0);
        send(W, 0, 0);
        send(0, H, 0);
        send(W - 1, H - 1, 1);
        drain(1, N);

        // Producer finishes during CLEAR: empty frame.
        start_frame(CW'($urandom_range(1, 255)), 1);
        tick();
        drain(2, N);

        // Random coordinates with repeats and out-of-range values.
        start_frame(CW'($urandom_range(1, 255)), 0);
        for (int i = 0; i < 24; i++)
            send(int'($urandom_range(0, W + 5)) - 3, int'($urandom_range(0, H + 5)) - 3, 0);
        pulse_done();
        drain(2, N);

        // Reset in the middle of readout, then a fresh frame must show no stale pixels.
        start_frame(CW'($urandom_range(1, 255)), 0);
        for (int i = 0; i < 10; i++)
            send(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 0);
        pulse_done();
        drain(0, 20);
        rst = 1'b1;
        tick();
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", ready, 0);
        check("midrst_done", done, 0);
        check("midrst_counts", {plotted, clipped}, 0);
        rst = 1'b0;
        start_frame(8'd9, 1);
        tick();
        drain(0, N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
